// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter for two requesters sharing one memory command
// port. Accepted reads are tracked in an in-order tag FIFO so that each
// returning read word can be steered back to the requester that issued it.
`timescale 1ns/1ps
module mem_arb #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 26,
  parameter int BYTEEN_WIDTH     = 8,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int TAG_DEPTH        = 16,
  parameter int RD_LATENCY       = 4
) (
  input  logic                        pClk,
  input  logic                        SoftReset,

  input  logic                        r0_write,
  input  logic                        r0_read,
  input  logic [ADDR_WIDTH-1:0]       r0_address,
  input  logic [DATA_WIDTH-1:0]       r0_writedata,
  input  logic [BYTEEN_WIDTH-1:0]     r0_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] r0_burstcount,
  input  logic [2:0]                  r0_readdata_sel,
  output logic                        r0_ready,
  output logic                        r0_rd_valid,
  output logic [DATA_WIDTH-1:0]       r0_rd_data,

  input  logic                        r1_write,
  input  logic                        r1_read,
  input  logic [ADDR_WIDTH-1:0]       r1_address,
  input  logic [DATA_WIDTH-1:0]       r1_writedata,
  input  logic [BYTEEN_WIDTH-1:0]     r1_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] r1_burstcount,
  input  logic [2:0]                  r1_readdata_sel,
  output logic                        r1_ready,
  output logic                        r1_rd_valid,
  output logic [DATA_WIDTH-1:0]       r1_rd_data,

  output logic                        mem_write,
  output logic                        mem_read,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  output logic [DATA_WIDTH-1:0]       mem_writedata,
  output logic [BYTEEN_WIDTH-1:0]     mem_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0] mem_burstcount,
  output logic [2:0]                  mem_readdata_sel,
  output logic                        mem_read_ddr_data,

  input  logic                        mem_cmd_fifo_full,
  input  logic                        mem_data_ready,
  input  logic [DATA_WIDTH-1:0]       mem_readdata,

  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        err_proto,
  output logic                        err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(TAG_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_t;

  arb_state_t state_reg;
  arb_state_t state_next;

  // Candidate selection and the muxed command of the candidate
  logic                        act0;
  logic                        act1;
  logic                        cand0;
  logic                        cand1;
  logic                        sel_write;
  logic                        sel_read;
  logic                        sel_read_only;
  logic [ADDR_WIDTH-1:0]       sel_address;
  logic [DATA_WIDTH-1:0]       sel_writedata;
  logic [BYTEEN_WIDTH-1:0]     sel_byteenable;
  logic [BURSTCOUNT_WIDTH-1:0] sel_burstcount;
  logic [2:0]                  sel_readdata_sel;

  // Handshake / FIFO control
  logic accept;
  logic stall;
  logic push;
  logic pop;
  logic tag_empty;
  logic head_id;

  // Registered command port
  logic                        mem_write_reg;
  logic                        mem_read_reg;
  logic [ADDR_WIDTH-1:0]       mem_address_reg;
  logic [DATA_WIDTH-1:0]       mem_writedata_reg;
  logic [BYTEEN_WIDTH-1:0]     mem_byteenable_reg;
  logic [BURSTCOUNT_WIDTH-1:0] mem_burstcount_reg;
  logic [2:0]                  mem_readdata_sel_reg;

  // Tag FIFO and status
  logic                        tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_reg;
  logic [PTR_W-1:0]            rd_ptr_reg;
  logic [PTR_W:0]              outstanding_reg;
  logic                        err_proto_reg;
  logic                        err_orphan_reg;

  // Response steering pipeline, one stage per cycle of read latency
  logic [RD_LATENCY-1:0]       pipe_valid_reg;
  logic [RD_LATENCY-1:0]       pipe_id_reg;

  // Pick the candidate requester and mux its command fields
  always_comb begin
    act0  = r0_write | r0_read;
    act1  = r1_write | r1_read;
    // With both active, the one not granted last time goes next.
    cand0 = act0 & (~act1 | (state_reg == LAST1));
    cand1 = act1 & (~act0 | (state_reg == LAST0));
    if (cand1) begin
      sel_write        = r1_write;
      sel_read         = r1_read;
      sel_address      = r1_address;
      sel_writedata    = r1_writedata;
      sel_byteenable   = r1_byteenable;
      sel_burstcount   = r1_burstcount;
      sel_readdata_sel = r1_readdata_sel;
    end else begin
      sel_write        = r0_write;
      sel_read         = r0_read;
      sel_address      = r0_address;
      sel_writedata    = r0_writedata;
      sel_byteenable   = r0_byteenable;
      sel_burstcount   = r0_burstcount;
      sel_readdata_sel = r0_readdata_sel;
    end
    // A combined write+read is executed as a write; the read is dropped.
    sel_read_only = sel_read & ~sel_write;
  end

  // Read-response pop: only when a read is actually in flight
  always_comb begin
    tag_empty = (outstanding_reg == '0);
    pop       = mem_data_ready & ~tag_empty & ~SoftReset;
    head_id   = tag_mem[rd_ptr_reg];
  end

  // Arbitration FSM next-state logic and the ready handshake
  always_comb begin
    state_next = state_reg;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    // A pop in the same cycle frees a tag slot, so a read may still be
    // taken while the FIFO is full as long as a response is leaving.
    stall = mem_cmd_fifo_full |
            (sel_read_only & (outstanding_reg == FULL_CNT) & ~pop);
    if ((cand0 | cand1) & ~stall & ~SoftReset) begin
      accept     = 1'b1;
      r0_ready   = cand0;
      r1_ready   = cand1;
      push       = sel_read_only;
      state_next = cand1 ? LAST1 : LAST0;
    end
  end

  // Arbitration FSM state register
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state_reg <= LAST1;
    end else begin
      state_reg <= state_next;
    end
  end

  // Register the accepted command; strobes last one cycle, fields hold
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      mem_write_reg        <= 1'b0;
      mem_read_reg         <= 1'b0;
      mem_address_reg      <= '0;
      mem_writedata_reg    <= '0;
      mem_byteenable_reg   <= '0;
      mem_burstcount_reg   <= '0;
      mem_readdata_sel_reg <= '0;
    end else begin
      mem_write_reg <= accept & sel_write;
      mem_read_reg  <= accept & sel_read_only;
      if (accept) begin
        mem_address_reg      <= sel_address;
        mem_writedata_reg    <= sel_writedata;
        mem_byteenable_reg   <= sel_byteenable;
        mem_burstcount_reg   <= sel_burstcount;
        mem_readdata_sel_reg <= sel_readdata_sel;
      end
    end
  end

  // Sticky protocol error flags
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      err_proto_reg  <= 1'b0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (accept & sel_write & sel_read) begin
        err_proto_reg <= 1'b1;
      end
      if (mem_data_ready & tag_empty) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end

  // Tag storage: requester ID of each accepted read, no reset needed
  always_ff @(posedge pClk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= cand1;
    end
  end

  // Tag FIFO pointers (wrap naturally) and in-flight read count
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_ONE;
        2'b01:   outstanding_reg <= outstanding_reg - CNT_ONE;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // Delay popped IDs until the matching data word appears on mem_readdata
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      pipe_valid_reg <= '0;
      pipe_id_reg    <= '0;
    end else begin
      pipe_valid_reg[0] <= pop;
      pipe_id_reg[0]    <= head_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_id_reg[i]    <= pipe_id_reg[i-1];
      end
    end
  end

  assign r0_rd_valid = pipe_valid_reg[RD_LATENCY-1] & ~pipe_id_reg[RD_LATENCY-1];
  assign r1_rd_valid = pipe_valid_reg[RD_LATENCY-1] &  pipe_id_reg[RD_LATENCY-1];
  assign r0_rd_data  = mem_readdata;
  assign r1_rd_data  = mem_readdata;

  assign mem_write         = mem_write_reg;
  assign mem_read          = mem_read_reg;
  assign mem_address       = mem_address_reg;
  assign mem_writedata     = mem_writedata_reg;
  assign mem_byteenable    = mem_byteenable_reg;
  assign mem_burstcount    = mem_burstcount_reg;
  assign mem_readdata_sel  = mem_readdata_sel_reg;
  assign mem_read_ddr_data = pop;

  assign outstanding = outstanding_reg;
  assign err_proto   = err_proto_reg;
  assign err_orphan  = err_orphan_reg;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb. Read responses are predicted
// when a pop is observed and compared when rN_rd_valid is due.
`timescale 1ns/1ps
module tb_mem_arb;

  localparam int DW = 64;
  localparam int AW = 26;
  localparam int BW = 8;
  localparam int CW = 7;
  localparam int TD = 16;
  localparam int RD_LAT = 4;

  logic          pClk;
  logic          SoftReset;
  logic          r0_write, r0_read, r1_write, r1_read;
  logic [AW-1:0] r0_address, r1_address;
  logic [DW-1:0] r0_writedata, r1_writedata;
  logic [BW-1:0] r0_byteenable, r1_byteenable;
  logic [CW-1:0] r0_burstcount, r1_burstcount;
  logic [2:0]    r0_readdata_sel, r1_readdata_sel;
  logic          r0_ready, r1_ready, r0_rd_valid, r1_rd_valid;
  logic [DW-1:0] r0_rd_data, r1_rd_data;
  logic          mem_write, mem_read, mem_read_ddr_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [BW-1:0] mem_byteenable;
  logic [CW-1:0] mem_burstcount;
  logic [2:0]    mem_readdata_sel;
  logic          mem_cmd_fifo_full, mem_data_ready;
  logic [DW-1:0] mem_readdata;
  logic [$clog2(TD):0] outstanding;
  logic          err_proto, err_orphan;

  mem_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW),
    .BURSTCOUNT_WIDTH(CW), .TAG_DEPTH(TD), .RD_LATENCY(RD_LAT)
  ) dut (
    .pClk(pClk), .SoftReset(SoftReset),
    .r0_write(r0_write), .r0_read(r0_read), .r0_address(r0_address),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_burstcount(r0_burstcount), .r0_readdata_sel(r0_readdata_sel),
    .r0_ready(r0_ready), .r0_rd_valid(r0_rd_valid), .r0_rd_data(r0_rd_data),
    .r1_write(r1_write), .r1_read(r1_read), .r1_address(r1_address),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_burstcount(r1_burstcount), .r1_readdata_sel(r1_readdata_sel),
    .r1_ready(r1_ready), .r1_rd_valid(r1_rd_valid), .r1_rd_data(r1_rd_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_burstcount(mem_burstcount), .mem_readdata_sel(mem_readdata_sel),
    .mem_read_ddr_data(mem_read_ddr_data),
    .mem_cmd_fifo_full(mem_cmd_fifo_full), .mem_data_ready(mem_data_ready),
    .mem_readdata(mem_readdata),
    .outstanding(outstanding), .err_proto(err_proto), .err_orphan(err_orphan)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q [$];
  int            id_q [$];
  logic [DW-1:0] data_q [$];
  logic [DW-1:0] rdat [int];

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int n_mem_read = 0;
  int n_rdv = 0;
  bit armed = 0;

  logic          pend_w, pend_r;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  logic s_r0_ready, s_r1_ready, s_r0_rd_valid, s_r1_rd_valid;
  logic s_mem_write, s_mem_read, s_ddr, s_err_proto, s_err_orphan;
  logic [$clog2(TD):0] s_outstanding;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle, compare against the model, then advance it.
  task automatic monitor();
    exp_t          e;
    logic          exp_v;
    int            id;
    logic [DW-1:0] d;
    s_r0_ready    = r0_ready;
    s_r1_ready    = r1_ready;
    s_r0_rd_valid = r0_rd_valid;
    s_r1_rd_valid = r1_rd_valid;
    s_mem_write   = mem_write;
    s_mem_read    = mem_read;
    s_ddr         = mem_read_ddr_data;
    s_err_proto   = err_proto;
    s_err_orphan  = err_orphan;
    s_outstanding = outstanding;
    if (armed) begin
      check_val("ready_excl", s_r0_ready & s_r1_ready, 0);
      check_val("mem_write", s_mem_write, pend_w);
      check_val("mem_read", s_mem_read, pend_r);
      check_val("mem_address", mem_address, exp_addr);
      check_val("mem_writedata", mem_writedata, exp_wdata);
      check_val("outstanding", s_outstanding, id_q.size());
      check_val("ddr", s_ddr, mem_data_ready && id_q.size() > 0 && !SoftReset);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cycle);
      check_val("rd_valid0", s_r0_rd_valid, exp_v && exp_q[0].id == 0);
      check_val("rd_valid1", s_r1_rd_valid, exp_v && exp_q[0].id == 1);
      if (exp_v) begin
        e = exp_q.pop_front();
        check_val("rd_data", (e.id == 1) ? r1_rd_data : r0_rd_data, e.data);
        $display("resp cycle %0d id %0d data %0h", cycle, e.id, e.data);
      end
    end
    if (s_mem_read) n_mem_read++;
    if (s_r0_rd_valid | s_r1_rd_valid) n_rdv++;
    if (SoftReset) begin
      exp_q.delete();
      id_q.delete();
      pend_w = 0; pend_r = 0; exp_addr = '0; exp_wdata = '0;
      armed = 1;
    end else if (armed) begin
      if (mem_data_ready && id_q.size() > 0) begin
        id = id_q.pop_front();
        d  = (data_q.size() > 0) ? data_q.pop_front() : {$urandom(), $urandom()};
        rdat[cycle + RD_LAT] = d;
        exp_q.push_back('{id, d, cycle + RD_LAT});
      end
      pend_w = 0; pend_r = 0;
      if (s_r0_ready | s_r1_ready) begin
        pend_w    = s_r1_ready ? r1_write : r0_write;
        pend_r    = s_r1_ready ? (r1_read & ~r1_write) : (r0_read & ~r0_write);
        exp_addr  = s_r1_ready ? r1_address : r0_address;
        exp_wdata = s_r1_ready ? r1_writedata : r0_writedata;
        if (pend_r) id_q.push_back(s_r1_ready ? 1 : 0);
      end
    end
  endtask

  task automatic cyc();
    @(negedge pClk);
    monitor();
    @(posedge pClk);
    #1;
    cycle++;
    mem_readdata = rdat.exists(cycle) ? rdat[cycle] : {$urandom(), $urandom()};
  endtask

  task automatic clear_inputs();
    r0_write = 0; r0_read = 0; r1_write = 0; r1_read = 0;
    r0_address = '0; r1_address = '0; r0_writedata = '0; r1_writedata = '0;
    r0_byteenable = '1; r1_byteenable = '1;
    r0_burstcount = 7'd1; r1_burstcount = 7'd1;
    r0_readdata_sel = 3'd0; r1_readdata_sel = 3'd1;
    mem_cmd_fifo_full = 0; mem_data_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int base;
    clear_inputs();
    mem_readdata = '0;
    pend_w = 0; pend_r = 0; exp_addr = '0; exp_wdata = '0;

    // Reset with requests pending: no ready while reset is high
    SoftReset = 1; r0_write = 1; r1_read = 1;
    cyc(); cyc();
    check_val("rst_ready0", s_r0_ready, 0);
    check_val("rst_ready1", s_r1_ready, 0);
    clear_inputs(); SoftReset = 0;
    cyc();
    check_val("rst_outstanding", s_outstanding, 0);
    check_val("rst_err_proto", s_err_proto, 0);
    check_val("rst_err_orphan", s_err_orphan, 0);
    check_val("rst_mem_write", s_mem_write, 0);

    // Both requesters writing: grants alternate starting with r0
    r0_write = 1; r1_write = 1; r0_address = 26'h100; r1_address = 26'h200;
    for (int i = 0; i < 6; i++) begin
      r0_writedata = 64'h1111_0000 + 64'(i);
      r1_writedata = 64'h2222_0000 + 64'(i);
      cyc();
      check_val("alt_grant0", s_r0_ready, (i % 2) == 0);
      check_val("alt_grant1", s_r1_ready, (i % 2) == 1);
      if (i > 0) check_val("alt_mem_write", s_mem_write, 1);
      $display("grant cycle %0d r0=%0b r1=%0b", cycle - 1, s_r0_ready, s_r1_ready);
    end
    clear_inputs(); cyc();

    // Command FIFO full stalls a read for 5 cycles, then one mem_read
    mem_cmd_fifo_full = 1; r0_read = 1; r0_address = 26'h10;
    base = n_mem_read;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_val("full_stall", s_r0_ready, 0);
    end
    mem_cmd_fifo_full = 0;
    cyc();
    check_val("full_release", s_r0_ready, 1);
    r0_read = 0;
    cyc(); cyc();
    check_val("one_mem_read", n_mem_read - base, 1);
    mem_data_ready = 1; cyc(); mem_data_ready = 0;
    repeat (6) cyc();

    // Fill the tag FIFO with r1 reads, then pop and refill in the same cycle
    r1_read = 1; n_acc = 0;
    for (int i = 0; i < 18; i++) begin
      r1_address = 26'(i);
      cyc();
      n_acc += int'(s_r1_ready);
    end
    check_val("fill_accepts", n_acc, TD);
    check_val("fill_stalled", s_r1_ready, 0);
    check_val("fill_outstanding", s_outstanding, TD);
    mem_data_ready = 1;
    cyc();
    check_val("pop_ddr", s_ddr, 1);
    check_val("pop_cycle_accept", s_r1_ready, 1);
    r1_read = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 2) check_val("lat_before", s_r1_rd_valid, 0);
      if (i == 3) check_val("lat_at4", s_r1_rd_valid, 1);
    end
    mem_data_ready = 0;
    repeat (6) cyc();
    check_val("drain_empty", exp_q.size(), 0);
    check_val("drain_outstanding", s_outstanding, 0);

    // Interleaved reads r0, r1, r0 returning 0xA, 0xB, 0xC
    r0_read = 1; r1_read = 1; r0_address = 26'h30; r1_address = 26'h40;
    cyc();
    check_val("il_grant_a", {s_r0_ready, s_r1_ready}, 2'b10);
    r0_address = 26'h31;
    cyc();
    check_val("il_grant_b", {s_r0_ready, s_r1_ready}, 2'b01);
    r1_read = 0;
    cyc();
    check_val("il_grant_c", {s_r0_ready, s_r1_ready}, 2'b10);
    r0_read = 0;
    data_q.push_back(64'hA); data_q.push_back(64'hB); data_q.push_back(64'hC);
    mem_data_ready = 1;
    repeat (3) cyc();
    mem_data_ready = 0;
    repeat (6) cyc();
    check_val("il_empty", exp_q.size(), 0);

    // Orphan data-ready, then a write+read command
    mem_data_ready = 1;
    cyc();
    check_val("orphan_ddr", s_ddr, 0);
    mem_data_ready = 0;
    cyc();
    check_val("err_orphan", s_err_orphan, 1);
    check_val("err_proto_pre", s_err_proto, 0);
    r0_write = 1; r0_read = 1; r0_address = 26'h55; r0_writedata = 64'hDEAD_BEEF;
    cyc();
    check_val("wr_rd_ready", s_r0_ready, 1);
    clear_inputs();
    cyc();
    check_val("wr_rd_mem_write", s_mem_write, 1);
    check_val("wr_rd_mem_read", s_mem_read, 0);
    check_val("err_proto", s_err_proto, 1);
    check_val("wr_rd_outstanding", s_outstanding, 0);

    // Reset two cycles after a pop discards the in-flight response
    r1_read = 1; r1_address = 26'h70;
    cyc(); cyc();
    r1_read = 0;
    base = n_rdv;
    mem_data_ready = 1; cyc(); mem_data_ready = 0;
    cyc();
    SoftReset = 1; cyc(); SoftReset = 0;
    cyc();
    check_val("rr_outstanding", s_outstanding, 0);
    check_val("rr_err_proto", s_err_proto, 0);
    check_val("rr_err_orphan", s_err_orphan, 0);
    repeat (6) cyc();
    check_val("rr_no_rd_valid", n_rdv - base, 0);
    check_val("end_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
